// File: rtl/instr_fetch.sv
// Instruction fetch unit with prefetch queue, redirect, and optional halt detector.
// Optional feature macro: IFETCH_HALT_EN (halt-word detection).
module instr_fetch #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [15:0]      RESET_PC  = 16'h0000,
    parameter int unsigned      QDEPTH    = 2,
    parameter logic [WIDTH-1:0] HALT_WORD = WIDTH'(16'hF000)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_en,
    output logic [15:0]      imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             redirect,
    input  logic [15:0]      redirect_pc,
    output logic             ins_valid,
    output logic [WIDTH-1:0] ins_data,
    output logic [15:0]      ins_pc,
    input  logic             ins_ready,
    output logic             halted
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    logic [15:0]      pc_q, pc_d;
    logic [WIDTH-1:0] word_q [QDEPTH];
    logic [15:0]      tag_q  [QDEPTH];
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             halt_q, halt_d;
    logic             push, pop, halt_hit;

    assign imem_addr = pc_q;
    assign ins_valid = (cnt_q != '0);
    assign ins_data  = ins_valid ? word_q[rd_q] : '0;
    assign ins_pc    = ins_valid ? tag_q[rd_q] : '0;
    assign halted    = halt_q;

    // A redirect discards the head rather than consuming it.
    assign pop  = ins_valid && ins_ready && !redirect;
    assign push = fetch_en && !redirect && !halt_q
                  && ((cnt_q < DEPTH_C) || pop);

`ifdef IFETCH_HALT_EN
    assign halt_hit = push && (imem_data == HALT_WORD);
`else
    logic unused_halt_word;
    assign unused_halt_word = ^HALT_WORD;
    assign halt_hit = 1'b0;
`endif

    always_comb begin
        pc_d   = pc_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        halt_d = halt_q;
        if (redirect) begin
            pc_d   = redirect_pc;
            rd_d   = '0;
            wr_d   = '0;
            cnt_d  = '0;
            halt_d = 1'b0;
        end else begin
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            if (push) begin
                wr_d = wr_q + 1'b1;
                // A halt word freezes the PC on the halt address.
                pc_d   = halt_hit ? pc_q : pc_q + 16'd1;
                halt_d = halt_hit;
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            halt_q <= 1'b0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                word_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            pc_q   <= pc_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            halt_q <= halt_d;
            if (push) begin
                word_q[wr_q] <= imem_data;
                tag_q[wr_q]  <= pc_q;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed scoreboard bench for instr_fetch; optional halt checks under IFETCH_HALT_EN.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ins_valid;
    logic [15:0] ins_data;
    logic [15:0] ins_pc;
    logic        ins_ready;
    logic        halted;

    int compared = 0;
    int mism = 0;

    typedef struct {
        logic [15:0] d;
        logic [15:0] pc;
    } ent_t;
    ent_t sb[$];

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_en   (fetch_en),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .ins_valid  (ins_valid),
        .ins_data   (ins_data),
        .ins_pc     (ins_pc),
        .ins_ready  (ins_ready),
        .halted     (halted)
    );

    function automatic logic [15:0] mem(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h8112;
            16'h0001: return 16'h0002;
            16'h0002: return 16'h0003;
`ifdef IFETCH_HALT_EN
            16'h0003: return 16'hF000;
`else
            16'h0003: return 16'h0004;
`endif
            16'h0009: return 16'hEFFA;
            16'hFFFF: return 16'h1234;
            default:  return a + 16'h1000;
        endcase
    endfunction

    assign imem_data = mem(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic want(input logic [15:0] d, input logic [15:0] pc);
        ent_t e;
        e.d  = d;
        e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic consume(input string tag);
        ent_t e;
        chk({tag, "_valid"}, 32'(ins_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_data"}, 32'(ins_data), 32'(e.d));
            chk({tag, "_pc"}, 32'(ins_pc), 32'(e.pc));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        fetch_en    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        ins_ready   = 1'b0;
        #12;
        chk("rst_valid", 32'(ins_valid), 32'd0);
        chk("rst_data", 32'(ins_data), 32'd0);
        chk("rst_pc", 32'(ins_pc), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'h0000);
        chk("rst_halted", 32'(halted), 32'd0);

        tick();
        rst_n     = 1'b1;
        fetch_en  = 1'b1;
        ins_ready = 1'b1;
        want(16'h8112, 16'h0000);
        want(16'h0002, 16'h0001);
        want(16'h0003, 16'h0002);
        tick();
        chk("latency_valid", 32'(ins_valid), 32'd1);
        consume("seq0");
        tick();
        consume("seq1");
        tick();
        consume("seq2");
        tick();

        ins_ready   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0000;
        tick();
        redirect = 1'b0;
        chk("redir0_addr", 32'(imem_addr), 32'h0000);
        chk("redir0_empty", 32'(ins_valid), 32'd0);
        repeat (5) tick();
        chk("bp_addr", 32'(imem_addr), 32'h0002);
        chk("bp_head", 32'(ins_data), 32'h8112);
        ins_ready = 1'b1;
        want(16'h8112, 16'h0000);
        want(16'h0002, 16'h0001);
        want(16'h0003, 16'h0002);
        consume("bp0");
        tick();
        consume("bp1");
        tick();
        consume("bp2");
        tick();

        ins_ready = 1'b0;
        repeat (2) tick();
        ins_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0009;
        tick();
        redirect = 1'b0;
        chk("br_bubble", 32'(ins_valid), 32'd0);
        chk("br_addr", 32'(imem_addr), 32'h0009);
        want(16'hEFFA, 16'h0009);
        want(16'h100A, 16'h000A);
        tick();
        consume("br0");
        tick();
        consume("br1");

        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        want(16'h1234, 16'hFFFF);
        want(16'h8112, 16'h0000);
        tick();
        consume("wrap0");
        tick();
        consume("wrap1");
        tick();

        ins_ready = 1'b0;
        repeat (3) tick();
        chk("full_valid", 32'(ins_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(ins_valid), 32'd0);
        chk("async_addr", 32'(imem_addr), 32'h0000);
        chk("async_data", 32'(ins_data), 32'd0);
        tick();
        rst_n     = 1'b1;
        ins_ready = 1'b1;
        want(16'h8112, 16'h0000);
        want(16'h0002, 16'h0001);
        want(16'h0003, 16'h0002);
        tick();
        consume("rs0");
        tick();
        consume("rs1");
        tick();
        consume("rs2");
        tick();
`ifdef IFETCH_HALT_EN
        want(16'hF000, 16'h0003);
        chk("halt_set", 32'(halted), 32'd1);
        consume("halt0");
        tick();
        chk("halt_addr", 32'(imem_addr), 32'h0003);
        chk("halt_drained", 32'(ins_valid), 32'd0);
        tick();
        chk("halt_addr2", 32'(imem_addr), 32'h0003);
        redirect    = 1'b1;
        redirect_pc = 16'h0000;
        tick();
        redirect = 1'b0;
        chk("halt_clr", 32'(halted), 32'd0);
        want(16'h8112, 16'h0000);
        tick();
        consume("resume0");
        chk("resume_addr", 32'(imem_addr), 32'h0001);
`else
        want(16'h0004, 16'h0003);
        consume("nohalt0");
        chk("nohalt", 32'(halted), 32'd0);
        tick();
        chk("nohalt_addr", 32'(imem_addr), 32'h0005);
`endif
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
